mega2_video_timing: RTL and testbench
=====================================

Name: mega2_video_timing

Overview:
- Mega II 1 MHz video timebase; drives the clock divider's `stretch` input, the other end of that interface.
- Counts 1 MHz slow cycles into horizontal and vertical positions: 65 cycles per line, 262 lines per frame (NTSC) or 312 (PAL).
- Asserts `stretch` during the 65th cycle of every line so the divider lengthens that cycle from 14 to 16 clk_14M clocks.
- Also supplies blanking flags, line/frame/VBL strobes and quarter-second/one-second ticks to the video and interrupt logic.

Parameters:
- H_TOTAL, 65, slow cycles per line.
- H_BLANK, 25, first H_BLANK cycles of each line are horizontal blank.
- STRETCH_H, 64, h_count value during which `stretch` is asserted.
- NTSC_LINES, 262, lines per frame when pal=0.
- PAL_LINES, 312, lines per frame when pal=1.
- QSEC_NTSC, 15, frames per quarter-second tick in NTSC.
- QSEC_PAL_A, 12, PAL quarter-second length in frames, used on even quarters.
- QSEC_PAL_B, 13, PAL quarter-second length in frames, used on odd quarters.

Ports:
- clk_14M  in  1  14.318 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- ph0_en  in  1  one-clock strobe marking the start of each Mega II 1 MHz cycle (from the clock divider).
- pal  in  1  1 = 50 Hz/312-line frame; 0 = 60 Hz/262-line frame.
- shr  in  1  1 = super hi-res, 200 active lines; 0 = 192 active lines.
- stretch  out  1  level; high for the whole STRETCH_H cycle.
- h_count  out  7  horizontal cycle index, 0..H_TOTAL-1.
- v_count  out  9  line index, 0..lines-1.
- hbl  out  1  h_count < H_BLANK.
- vbl  out  1  v_count >= active lines.
- line_start  out  1  one-clock pulse when h_count wraps to 0.
- vbl_start  out  1  one-clock pulse on entry to v_count = active lines, h_count = 0.
- frame_start  out  1  one-clock pulse when both counters wrap to 0.
- qsec_tick  out  1  one-clock pulse per quarter second.
- sec_tick  out  1  one-clock pulse per second.

Behaviour:
- Reset (async, immediate): h_count=0, v_count=0, stretch=0, hbl=1, vbl=0, all pulse outputs 0, frame and quarter counters 0.
- pal and shr are latched at reset release, then internally captured only on the clock where frame_start fires.
- All outputs are registered and update on the first clk_14M edge at which ph0_en=1; latency is one clock from the strobe.
- With no ph0_en, all state holds and all pulse outputs are 0.
- Horizontal: h_count increments on each ph0_en and wraps H_TOTAL-1 -> 0.
- Vertical: v_count increments only on the h wrap. It wraps lines-1 -> 0, with lines = PAL_LINES or NTSC_LINES from the latched pal.
- stretch is registered as (next h_count == STRETCH_H): rises with the strobe that enters cycle 64 and falls with the strobe that enters cycle 0.
- hbl and vbl are combinational from the registered counters, or registered with identical timing. Active lines = 200 if latched shr, else 192.
- line_start, vbl_start and frame_start all assert on the same clock as the counter update they mark.
- frame_start implies line_start on the same clock.
- Quarter-second counter: counts frame_start pulses.
  - NTSC: qsec_tick fires on the 15th frame, then the counter clears.
  - PAL: alternates 12 then 13 frames (25 frames per half second). A phase bit toggles on each qsec_tick.
- qsec_tick coincides with the triggering frame_start.
- sec_tick fires together with every 4th qsec_tick; the quarter index is 2 bits, wrapping 3 -> 0.
- A pal change mid-frame does not alter the current frame length. On the change it takes effect at the next frame, the frame counter clears and the PAL phase resets to A.
- Back-to-back ph0_en on consecutive clocks is counted per strobe; there is no filtering.
- Reset asserted mid-line forces all outputs to reset values on the next evaluation, without waiting for a clock edge. stretch must drop immediately.

Decomposition:
- Shared package mega2_timing_pkg holds:
  - H_TOTAL, H_BLANK, STRETCH_H;
  - NTSC_LINES, PAL_LINES;
  - ACTIVE_LINES_TEXT=192, ACTIVE_LINES_SHR=200;
  - the quarter-second frame counts.
- One sub-module, mega2_tick_div: frame_start in -> qsec_tick/sec_tick out, with the NTSC/PAL 12/13 alternation.
- The h/v counters stay in the top level.

Test Plan:
1. Reset, then 65 ph0_en strobes spaced 14 clocks apart -> h_count runs 0..64. stretch is high only while h_count=64. On strobe 65: h_count=0, v_count=1, line_start is one clock wide.
2. NTSC, shr=0, 262*65 strobes -> vbl_start at v=192/h=0, vbl high for v=192..261, frame_start with v 261->0.
3. shr=1 applied mid-frame -> current frame still gives vbl_start at v=192; next frame gives vbl_start at v=200.
4. pal=1 set at v=100 -> current frame wraps at 261. Next frame wraps at 311. qsec_tick fires after PAL frames 12, 25, 37 and 50; sec_tick fires at frame 50.
5. NTSC, 60 frames -> qsec_tick at frames 15/30/45/60, sec_tick only at frame 60. No qsec_tick without ph0_en.
6. Async reset pulse at h=64 (stretch high), v=150 -> all outputs zero and stretch low before the next clk_14M edge; counting restarts cleanly after release.

Source files
------------

// File: rtl/mega2_timing_pkg.sv
// Shared constants and helpers for the Mega II 1 MHz video timebase.
package mega2_timing_pkg;

    typedef enum logic {
        STD_NTSC = 1'b0,
        STD_PAL  = 1'b1
    } video_std_t;

    localparam logic [6:0] H_TOTAL   = 7'd65;
    localparam logic [6:0] H_BLANK   = 7'd25;
    localparam logic [6:0] STRETCH_H = 7'd64;

    localparam logic [8:0] NTSC_LINES        = 9'd262;
    localparam logic [8:0] PAL_LINES         = 9'd312;
    localparam logic [8:0] ACTIVE_LINES_TEXT = 9'd192;
    localparam logic [8:0] ACTIVE_LINES_SHR  = 9'd200;

    localparam logic [3:0] QSEC_NTSC  = 4'd15;
    localparam logic [3:0] QSEC_PAL_A = 4'd12;
    localparam logic [3:0] QSEC_PAL_B = 4'd13;

    // PAL alternates 12/13 frames so two quarters add up to exactly 25 frames.
    function automatic logic [3:0] qsec_frames(input video_std_t video_std,
                                               input logic       phase_b);
        logic [3:0] frames;
        frames = QSEC_NTSC;
        if (video_std == STD_PAL) begin
            frames = phase_b ? QSEC_PAL_B : QSEC_PAL_A;
        end
        return frames;
    endfunction

endpackage

// File: rtl/mega2_tick_div.sv
// Divides frame wraps into quarter-second and one-second ticks.
module mega2_tick_div
    import mega2_timing_pkg::*;
(
    input  logic       clk_14M,
    input  logic       reset,
    input  logic       frame_wrap,
    input  logic       std_change,
    input  video_std_t video_std,
    output logic       qsec_tick,
    output logic       sec_tick
);

    logic [3:0] frame_cnt_reg;
    logic [3:0] frame_cnt_next;
    logic [1:0] quarter_reg;
    logic       phase_b_reg;
    logic       qsec_tick_reg;
    logic       sec_tick_reg;
    logic       quarter_done;

    assign frame_cnt_next = frame_cnt_reg + 4'd1;
    assign quarter_done   = (frame_cnt_next == qsec_frames(video_std, phase_b_reg));

    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= '0;
            quarter_reg   <= '0;
            phase_b_reg   <= 1'b0;
            qsec_tick_reg <= 1'b0;
            sec_tick_reg  <= 1'b0;
        end else begin
            qsec_tick_reg <= 1'b0;
            sec_tick_reg  <= 1'b0;
            if (frame_wrap) begin
                // A standard switch restarts the whole second on the new frame rate.
                if (std_change) begin
                    frame_cnt_reg <= '0;
                    quarter_reg   <= '0;
                    phase_b_reg   <= 1'b0;
                end else if (quarter_done) begin
                    frame_cnt_reg <= '0;
                    quarter_reg   <= quarter_reg + 2'd1;
                    phase_b_reg   <= ~phase_b_reg;
                    qsec_tick_reg <= 1'b1;
                    sec_tick_reg  <= (quarter_reg == 2'd3);
                end else begin
                    frame_cnt_reg <= frame_cnt_next;
                end
            end
        end
    end

    assign qsec_tick = qsec_tick_reg;
    assign sec_tick  = sec_tick_reg;

endmodule

// File: rtl/mega2_video_timing.sv
// Mega II 1 MHz video timebase: h/v counters, blanking, strobes and the
// divider stretch request for the long last cycle of each line.
module mega2_video_timing
    import mega2_timing_pkg::*;
#(
    parameter logic [6:0] P_H_TOTAL     = H_TOTAL,
    parameter logic [6:0] P_H_BLANK     = H_BLANK,
    parameter logic [6:0] P_STRETCH_H   = STRETCH_H,
    parameter logic [8:0] P_NTSC_LINES  = NTSC_LINES,
    parameter logic [8:0] P_PAL_LINES   = PAL_LINES,
    parameter logic [8:0] P_ACTIVE_TEXT = ACTIVE_LINES_TEXT,
    parameter logic [8:0] P_ACTIVE_SHR  = ACTIVE_LINES_SHR
)
(
    input  logic       clk_14M,
    input  logic       reset,
    input  logic       ph0_en,
    input  logic       pal,
    input  logic       shr,
    output logic       stretch,
    output logic [6:0] h_count,
    output logic [8:0] v_count,
    output logic       hbl,
    output logic       vbl,
    output logic       line_start,
    output logic       vbl_start,
    output logic       frame_start,
    output logic       qsec_tick,
    output logic       sec_tick
);

    logic [6:0] h_count_reg;
    logic [6:0] h_count_next;
    logic [8:0] v_count_reg;
    logic [8:0] v_count_next;
    logic       stretch_reg;
    logic       line_start_reg;
    logic       vbl_start_reg;
    logic       frame_start_reg;
    video_std_t video_std_reg;
    logic       shr_reg;
    logic       init_reg;

    logic [8:0] lines_total;
    logic [8:0] active_lines;
    logic       h_last;
    logic       v_last;
    logic       frame_wrap;
    logic       std_change;

    always_comb begin
        lines_total  = (video_std_reg == STD_PAL) ? P_PAL_LINES : P_NTSC_LINES;
        active_lines = shr_reg ? P_ACTIVE_SHR : P_ACTIVE_TEXT;
        h_last       = (h_count_reg == P_H_TOTAL - 7'd1);
        v_last       = (v_count_reg == lines_total - 9'd1);
        h_count_next = h_last ? 7'd0 : h_count_reg + 7'd1;
        v_count_next = v_count_reg;
        if (h_last) begin
            v_count_next = v_last ? 9'd0 : v_count_reg + 9'd1;
        end
    end

    assign frame_wrap = ph0_en && h_last && v_last;
    assign std_change = frame_wrap && (video_std_t'(pal) != video_std_reg);

    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            h_count_reg     <= '0;
            v_count_reg     <= '0;
            stretch_reg     <= 1'b0;
            line_start_reg  <= 1'b0;
            vbl_start_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            video_std_reg   <= STD_NTSC;
            shr_reg         <= 1'b0;
            init_reg        <= 1'b1;
        end else begin
            line_start_reg  <= 1'b0;
            vbl_start_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            init_reg        <= 1'b0;
            // Mode inputs only move at frame boundaries so a frame never changes shape midway.
            if (init_reg || frame_wrap) begin
                video_std_reg <= video_std_t'(pal);
                shr_reg       <= shr;
            end
            if (ph0_en) begin
                h_count_reg     <= h_count_next;
                v_count_reg     <= v_count_next;
                stretch_reg     <= (h_count_next == P_STRETCH_H);
                line_start_reg  <= h_last;
                vbl_start_reg   <= h_last && (v_count_next == active_lines);
                frame_start_reg <= h_last && v_last;
            end
        end
    end

    mega2_tick_div u_tick_div (
        .clk_14M    (clk_14M),
        .reset      (reset),
        .frame_wrap (frame_wrap),
        .std_change (std_change),
        .video_std  (video_std_reg),
        .qsec_tick  (qsec_tick),
        .sec_tick   (sec_tick)
    );

    assign stretch     = stretch_reg;
    assign h_count     = h_count_reg;
    assign v_count     = v_count_reg;
    assign hbl         = (h_count_reg < P_H_BLANK);
    assign vbl         = (v_count_reg >= active_lines);
    assign line_start  = line_start_reg;
    assign vbl_start   = vbl_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_mega2_video_timing.sv
// Bench for mega2_video_timing: full-size instance for line/frame geometry,
// shrunken-geometry instance for the quarter/second tick sequences.
module tb_mega2_video_timing;

    logic clk_14M = 1'b0;
    always #5 clk_14M = ~clk_14M;

    logic       rst_a, ph_a, pal_a, shr_a;
    logic       st_a, hbl_a, vbl_a, ls_a, vs_a, fs_a, q_a, s_a;
    logic [6:0] h_a;
    logic [8:0] v_a;

    logic       rst_b, ph_b, pal_b, shr_b;
    logic       st_b, hbl_b, vbl_b, ls_b, vs_b, fs_b, q_b, s_b;
    logic [6:0] h_b;
    logic [8:0] v_b;

    mega2_video_timing dut_a (
        .clk_14M(clk_14M), .reset(rst_a), .ph0_en(ph_a), .pal(pal_a), .shr(shr_a),
        .stretch(st_a), .h_count(h_a), .v_count(v_a), .hbl(hbl_a), .vbl(vbl_a),
        .line_start(ls_a), .vbl_start(vs_a), .frame_start(fs_a),
        .qsec_tick(q_a), .sec_tick(s_a)
    );

    // 8 cycles per line, 10/12 lines per frame, 6/8 active lines.
    mega2_video_timing #(
        .P_H_TOTAL(7'd8), .P_H_BLANK(7'd3), .P_STRETCH_H(7'd7),
        .P_NTSC_LINES(9'd10), .P_PAL_LINES(9'd12),
        .P_ACTIVE_TEXT(9'd6), .P_ACTIVE_SHR(9'd8)
    ) dut_b (
        .clk_14M(clk_14M), .reset(rst_b), .ph0_en(ph_b), .pal(pal_b), .shr(shr_b),
        .stretch(st_b), .h_count(h_b), .v_count(v_b), .hbl(hbl_b), .vbl(vbl_b),
        .line_start(ls_b), .vbl_start(vs_b), .frame_start(fs_b),
        .qsec_tick(q_b), .sec_tick(s_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int n;
        int h;
        int v;
        int st;
        int hbl;
        int ls;
    } vec_t;
    vec_t vecs[7];

    int fr_b, st_cnt_b, last_fs_st, bad_b;
    int qlog[$];
    int slog[$];
    int ntsc_q[4] = '{15, 30, 45, 60};
    int pal_q[4]  = '{12, 25, 37, 50};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
        else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic step_a(input logic en);
        ph_a = en;
        @(posedge clk_14M);
        #1;
        ph_a = 1'b0;
    endtask

    task automatic strobe_spaced_a();
        repeat (13) step_a(1'b0);
        step_a(1'b1);
    endtask

    task automatic strobe_b();
        ph_b = 1'b1;
        @(posedge clk_14M);
        #1;
        ph_b = 1'b0;
        st_cnt_b++;
        if (fs_b) begin
            fr_b++;
            last_fs_st = st_cnt_b;
        end
        if (q_b) begin
            qlog.push_back(fr_b);
            if (!fs_b) bad_b++;
        end
        if (s_b) begin
            slog.push_back(fr_b);
            if (!q_b) bad_b++;
        end
    endtask

    task automatic run_frame_a(input string tag, input int lines, input int active,
                               input int chg_v, input logic new_shr, input logic new_pal);
        int total, vs_cnt, vs_v, vs_h, vbl_cnt, fs_cnt, fs_k, max_v, ls_cnt, st_cnt, fs_no_ls;
        total = lines * 65;
        vs_cnt = 0; vs_v = -1; vs_h = -1; vbl_cnt = 0; fs_cnt = 0; fs_k = -1;
        max_v = 0; ls_cnt = 0; st_cnt = 0; fs_no_ls = 0;
        for (int k = 1; k <= total; k++) begin
            step_a(1'b1);
            if (vs_a) begin
                vs_cnt++;
                vs_v = int'(v_a);
                vs_h = int'(h_a);
            end
            if (vbl_a) vbl_cnt++;
            if (fs_a) begin
                fs_cnt++;
                fs_k = k;
                if (!ls_a) fs_no_ls++;
            end
            if (ls_a) ls_cnt++;
            if (st_a) st_cnt++;
            if (int'(v_a) > max_v) max_v = int'(v_a);
            if (k == chg_v * 65) begin
                shr_a = new_shr;
                pal_a = new_pal;
            end
        end
        check({tag, "_vbl_start_count"}, vs_cnt, 1);
        check({tag, "_vbl_start_v"}, vs_v, active);
        check({tag, "_vbl_start_h"}, vs_h, 0);
        check({tag, "_vbl_cycles"}, vbl_cnt, (lines - active) * 65);
        check({tag, "_frame_start_count"}, fs_cnt, 1);
        check({tag, "_frame_start_at"}, fs_k, total);
        check({tag, "_max_v"}, max_v, lines - 1);
        check({tag, "_line_starts"}, ls_cnt, lines);
        check({tag, "_stretch_cycles"}, st_cnt, lines);
        check({tag, "_fs_without_ls"}, fs_no_ls, 0);
        check({tag, "_end_h"}, int'(h_a), 0);
        check({tag, "_end_v"}, int'(v_a), 0);
    endtask

    task automatic seq_a();
        int done_n, st_bad;
        vecs[0] = '{0,  0,  0, 0, 1, 0};
        vecs[1] = '{1,  1,  0, 0, 1, 0};
        vecs[2] = '{24, 24, 0, 0, 1, 0};
        vecs[3] = '{25, 25, 0, 0, 0, 0};
        vecs[4] = '{63, 63, 0, 0, 0, 0};
        vecs[5] = '{64, 64, 0, 1, 0, 0};
        vecs[6] = '{65, 0,  1, 0, 1, 1};
        done_n = 0;
        st_bad = 0;
        for (int i = 0; i < 7; i++) begin
            while (done_n < vecs[i].n) begin
                strobe_spaced_a();
                done_n++;
                if (int'(st_a) != int'(h_a == 7'd64)) st_bad++;
            end
            check($sformatf("t1_h@%0d", vecs[i].n), int'(h_a), vecs[i].h);
            check($sformatf("t1_v@%0d", vecs[i].n), int'(v_a), vecs[i].v);
            check($sformatf("t1_stretch@%0d", vecs[i].n), int'(st_a), vecs[i].st);
            check($sformatf("t1_hbl@%0d", vecs[i].n), int'(hbl_a), vecs[i].hbl);
            check($sformatf("t1_line_start@%0d", vecs[i].n), int'(ls_a), vecs[i].ls);
        end
        check("t1_stretch_only_at_64", st_bad, 0);
        step_a(1'b0);
        check("t1_line_start_width", int'(ls_a), 0);
        repeat (12) step_a(1'b0);
        check("t1_hold_h", int'(h_a), 0);
        check("t1_hold_v", int'(v_a), 1);

        rst_a = 1'b1;
        @(posedge clk_14M);
        #1;
        rst_a = 1'b0;
        step_a(1'b0);

        run_frame_a("t2_ntsc", 262, 192, 100, 1'b1, 1'b0);
        run_frame_a("t3_shr", 262, 200, 100, 1'b1, 1'b1);
        run_frame_a("t4_pal", 312, 200, -1, 1'b1, 1'b1);

        repeat (150 * 65 + 64) step_a(1'b1);
        check("t6_pre_h", int'(h_a), 64);
        check("t6_pre_v", int'(v_a), 150);
        check("t6_pre_stretch", int'(st_a), 1);
        rst_a = 1'b1;
        #1;
        check("t6_async_stretch", int'(st_a), 0);
        check("t6_async_h", int'(h_a), 0);
        check("t6_async_v", int'(v_a), 0);
        check("t6_async_hbl", int'(hbl_a), 1);
        check("t6_async_vbl", int'(vbl_a), 0);
        check("t6_async_pulses", int'(ls_a | vs_a | fs_a | q_a | s_a), 0);
        @(posedge clk_14M);
        #1;
        rst_a = 1'b0;
        step_a(1'b0);
        step_a(1'b1);
        check("t6_restart_h", int'(h_a), 1);
        check("t6_restart_v", int'(v_a), 0);
        check("t6_restart_stretch", int'(st_a), 0);
        repeat (63) step_a(1'b1);
        check("t6_restart_h64", int'(h_a), 64);
        check("t6_restart_stretch64", int'(st_a), 1);
    endtask

    task automatic seq_b();
        int pulses, t0, n;
        fr_b = 0; st_cnt_b = 0; last_fs_st = 0; bad_b = 0;
        qlog.delete();
        slog.delete();

        repeat (59 * 80 + 79) strobe_b();
        check("t5_qsec_before_idle", qlog.size(), 3);
        pulses = 0;
        repeat (50) begin
            @(posedge clk_14M);
            #1;
            if (q_b | s_b | fs_b | ls_b | vs_b) pulses++;
        end
        check("t5_idle_pulses", pulses, 0);
        check("t5_idle_hold_h", int'(h_b), 7);
        check("t5_idle_hold_v", int'(v_b), 9);
        strobe_b();
        check("t5_qsec_at_60", int'(q_b), 1);
        check("t5_sec_at_60", int'(s_b), 1);
        check("t5_frame_start_at_60", int'(fs_b), 1);
        check("t5_line_start_at_60", int'(ls_b), 1);
        check("t5_qsec_count", qlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_qsec_frame%0d", i), (i < qlog.size()) ? qlog[i] : -1, ntsc_q[i]);
        end
        check("t5_sec_count", slog.size(), 1);
        check("t5_sec_frame", (slog.size() > 0) ? slog[0] : -1, 60);

        repeat (20 * 80 + 40) strobe_b();
        check("t4_switch_v", int'(v_b), 5);
        check("t4_switch_h", int'(h_b), 0);
        pal_b = 1'b1;
        qlog.delete();
        slog.delete();
        t0 = st_cnt_b;
        n = 0;
        while (!fs_b && n < 200) begin
            strobe_b();
            n++;
        end
        check("t4_transition_len", st_cnt_b - t0, 40);
        check("t4_no_tick_at_switch", qlog.size(), 0);
        fr_b = 0;
        t0 = st_cnt_b;
        repeat (95) strobe_b();
        check("t4_pal_last_v", int'(v_b), 11);
        check("t4_pal_last_h", int'(h_b), 7);
        strobe_b();
        check("t4_pal_wrap", int'(fs_b), 1);
        check("t4_pal_frame_len", last_fs_st - t0, 96);
        repeat (49 * 96) strobe_b();
        check("t4_pal_frames", fr_b, 50);
        check("t4_qsec_count", qlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_qsec_frame%0d", i), (i < qlog.size()) ? qlog[i] : -1, pal_q[i]);
        end
        check("t4_sec_count", slog.size(), 1);
        check("t4_sec_frame", (slog.size() > 0) ? slog[0] : -1, 50);
        check("t45_tick_alignment", bad_b, 0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ph_a = 1'b0; ph_b = 1'b0;
        pal_a = 1'b0; shr_a = 1'b0;
        pal_b = 1'b0; shr_b = 1'b0;
        repeat (3) @(posedge clk_14M);
        #1;
        check("rst_h", int'(h_a), 0);
        check("rst_stretch", int'(st_a), 0);
        check("rst_hbl", int'(hbl_a), 1);
        check("rst_vbl", int'(vbl_a), 0);
        check("rst_pulses", int'(ls_a | vs_a | fs_a | q_a | s_a), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk_14M);
        #1;
        fork
            seq_a();
            seq_b();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
